// File: rtl/fetch_unit_if.sv
// =============================================================================
// Module   : fetch_unit_if
// Brief    : Fetch-stage bundle: inst_mem address/data, control, IF/ID handshake
// Revision : 1.0
// =============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadAddr;
    logic [31:0]       Instruccion;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              out_valid;
    logic              out_ready;
    logic              halted;

    // master = the fetch unit itself, slave = memory/decode/hazard side
    modport master (
        output ReadAddr,
        input  Instruccion,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr_out,
        output pc_out,
        output out_valid,
        input  out_ready,
        output halted
    );

    modport slave (
        input  ReadAddr,
        output Instruccion,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr_out,
        input  pc_out,
        input  out_valid,
        output out_ready,
        input  halted
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// =============================================================================
// Module   : fetch_unit
// Brief    : PC + IF/ID register with valid/ready output, stall and redirect.
//            Optional halt-on-opcode support guarded by macro FETCH_HALT_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W     = 5,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]       NOP_INSTR  = 32'h0000_0000,
    parameter logic [31:0]       HALT_INSTR = 32'hFFFF_FFFF
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_unit_if.master  bus
);

    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1
    } state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_out;
    logic [31:0]       r_instr;
    logic              r_valid;
`ifdef FETCH_HALT_EN
    logic              r_halted;
`endif

    logic              w_take;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_next;

    // IF/ID slot is free when empty or being drained on this edge
    assign w_take    = !r_valid || bus.out_ready;
    assign w_target  = bus.redirect_pc & c_align_mask;
    assign w_pc_next = r_pc + c_pc_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_pc_out <= '0;
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (bus.redirect) begin
            // Flush wins over stall and backpressure alike
            r_pc    <= w_target;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (!bus.stall) begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_take) begin
                        r_instr  <= bus.Instruccion;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
`ifdef FETCH_HALT_EN
                        if (bus.Instruccion == HALT_INSTR) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                        end
`else
                        r_pc <= w_pc_next;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                S_HALT: begin
                    // Present the halt word once, then go quiet
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.ReadAddr  = r_pc;
    assign bus.instr_out = r_instr;
    assign bus.pc_out    = r_pc_out;
    assign bus.out_valid = r_valid;
`ifdef FETCH_HALT_EN
    assign bus.halted    = r_halted;
`else
    assign bus.halted    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// =============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed scenarios plus randomized scoreboard run for fetch_unit
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int          AW  = 5;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW)) bus ();

    logic [31:0] mem [8];
    assign bus.Instruccion = mem[bus.ReadAddr[4:2]];

    fetch_unit #(
        .ADDR_W    (AW),
        .RESET_PC  (5'd0),
        .NOP_INSTR (NOP),
        .HALT_INSTR(32'hFFFF_FFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: samples just before each rising edge, pops on every transfer
    initial begin : monitor
        logic        pv_hold;
        logic        pv_redir;
        logic [31:0] pv_instr;
        logic [4:0]  pv_pc;
        exp_t        e;
        pv_hold  = 1'b0;
        pv_redir = 1'b0;
        pv_instr = '0;
        pv_pc    = '0;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                if (pv_redir) begin
                    chk("flush_valid", 32'(bus.out_valid), 32'd0);
                end else if (pv_hold) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_instr", bus.instr_out, pv_instr);
                    chk("hold_pc_out", 32'(bus.pc_out), 32'(pv_pc));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow actual=transfer expected=none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc_out", 32'(bus.pc_out), 32'(e.pc));
                        chk("sb_instr", bus.instr_out, e.instr);
                        chk("sb_halted", 32'(bus.halted), 32'd0);
                        xfers++;
                    end
                end
                pv_redir = bus.redirect;
                pv_hold  = bus.out_valid && !bus.out_ready && !bus.redirect;
                pv_instr = bus.instr_out;
                pv_pc    = bus.pc_out;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        logic [4:0] next_pc;
        logic [4:0] tgt;
        bit         redir_prev;

        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;
        mem[0] = 32'h1122_3344;
        for (int i = 1; i < 8; i++) mem[i] = $urandom & 32'hFFFF_FFFE;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_instr", bus.instr_out, NOP);
        chk("reset_pc_out", 32'(bus.pc_out), 32'd0);
        chk("reset_readaddr", 32'(bus.ReadAddr), 32'd0);
        chk("reset_halted", 32'(bus.halted), 32'd0);

        // Boot edge, then first capture
        reset = 1'b0;
        tick();
        chk("boot_valid", 32'(bus.out_valid), 32'd0);
        chk("boot_readaddr", 32'(bus.ReadAddr), 32'd0);
        tick();
        chk("first_instr", bus.instr_out, 32'h1122_3344);
        chk("first_pc_out", 32'(bus.pc_out), 32'd0);
        chk("first_readaddr", 32'(bus.ReadAddr), 32'd4);
        chk("first_valid", 32'(bus.out_valid), 32'd1);

        // Backpressure
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_instr", bus.instr_out, mem[0]);
            chk("bp_pc_out", 32'(bus.pc_out), 32'd0);
            chk("bp_readaddr", 32'(bus.ReadAddr), 32'd4);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("xfer_pc_out", 32'(bus.pc_out), 32'd4);
        chk("xfer_instr", bus.instr_out, mem[1]);
        chk("xfer_readaddr", 32'(bus.ReadAddr), 32'd8);

        // Redirect with unaligned target under backpressure
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'h13;
        tick();
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_readaddr", 32'(bus.ReadAddr), 32'h10);
        chk("redir_instr", bus.instr_out, NOP);
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("redir_pc_out", 32'(bus.pc_out), 32'h10);
        chk("redir_tgt_instr", bus.instr_out, mem[4]);

        // Wrap-around from 0x18
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'h18;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("wrap_pc_18", 32'(bus.pc_out), 32'h18);
        tick();
        chk("wrap_pc_1c", 32'(bus.pc_out), 32'h1C);
        tick();
        chk("wrap_pc_00", 32'(bus.pc_out), 32'h00);
        chk("wrap_readaddr", 32'(bus.ReadAddr), 32'h04);

        // Stall freezes everything; redirect beats stall
        bus.stall = 1'b1;
        repeat (2) begin
            tick();
            chk("stall_pc_out", 32'(bus.pc_out), 32'h00);
            chk("stall_readaddr", 32'(bus.ReadAddr), 32'h04);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_instr", bus.instr_out, mem[0]);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'h08;
        tick();
        chk("stall_redir_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_redir_readaddr", 32'(bus.ReadAddr), 32'h08);
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        tick();
        chk("post_stall_pc_out", 32'(bus.pc_out), 32'h08);
        chk("post_stall_instr", bus.instr_out, mem[2]);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_readaddr", 32'(bus.ReadAddr), 32'd0);
        chk("async_pc_out", 32'(bus.pc_out), 32'd0);
        chk("async_instr", bus.instr_out, NOP);
        @(negedge clk);
        reset  = 1'b0;
        mem[2] = 32'hFFFF_FFFF;

`ifdef FETCH_HALT_EN
        tick();
        tick();
        tick();
        tick();
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_valid", 32'(bus.out_valid), 32'd1);
        chk("halt_instr", bus.instr_out, 32'hFFFF_FFFF);
        chk("halt_readaddr", 32'(bus.ReadAddr), 32'h08);
        tick();
        chk("halt_drop_valid", 32'(bus.out_valid), 32'd0);
        chk("halt_stay_readaddr", 32'(bus.ReadAddr), 32'h08);
        tick();
        chk("halt_quiet_valid", 32'(bus.out_valid), 32'd0);
        chk("halt_quiet_halted", 32'(bus.halted), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'h00;
        tick();
        chk("halt_exit_halted", 32'(bus.halted), 32'd0);
        bus.redirect = 1'b0;
        tick();
        chk("halt_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("halt_resume_pc_out", 32'(bus.pc_out), 32'h00);
`else
        tick();
        tick();
        tick();
        tick();
        chk("ordinary_ffff_instr", bus.instr_out, 32'hFFFF_FFFF);
        chk("ordinary_ffff_readaddr", 32'(bus.ReadAddr), 32'h0C);
        chk("ordinary_ffff_halted", 32'(bus.halted), 32'd0);
`endif
        mem[2] = $urandom & 32'hFFFF_FFFE;

        // Randomized phase: model tracks the in-order word stream
        next_pc         = '0;
        bus.stall       = 1'b0;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'($urandom_range(0, 31));
        tgt             = bus.redirect_pc;
        redir_prev      = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (redir_prev) begin
                exp_q.delete();
                next_pc = tgt & 5'h1C;
                mon_en  = 1'b1;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back('{pc: next_pc, instr: mem[next_pc[4:2]]});
                next_pc = next_pc + 5'd4;
            end
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = 5'($urandom_range(0, 31));
            bus.stall       = ($urandom_range(0, 7) == 0);
            bus.out_ready   = bus.stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            redir_prev      = bus.redirect;
            tgt             = bus.redirect_pc;
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("xfer_count_min", 32'(xfers > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
